// File: rtl/ebus_pkg.sv
// Shared types and default sizes for the KL10PV EBUS data arbiter.
package ebus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } ebus_state_t;

    localparam int EBUS_DATA_W = 36;
    localparam int EBUS_N_DRV  = 30;

endpackage

// File: rtl/ebus_arb_mux_if.sv
// EBUS driver-side handshake and shared-bus signal bundle.
interface ebus_arb_mux_if #(
    parameter int N_DRV  = 30,
    parameter int DATA_W = 36
);
    localparam int IDX_W = $clog2(N_DRV);

    logic [N_DRV-1:0]             drv_req;
    logic [N_DRV-1:0][DATA_W-1:0] drv_data;
    logic [N_DRV-1:0]             drv_grant;
    logic [DATA_W-1:0]            ebus_data;
    logic                         ebus_valid;
    logic [IDX_W-1:0]             owner_idx;
    logic                         hold_err;
    logic [IDX_W-1:0]             hold_err_idx;
    logic                         err_clr;

    modport master (
        output drv_req, drv_data, err_clr,
        input  drv_grant, ebus_data, ebus_valid, owner_idx, hold_err, hold_err_idx
    );

    modport slave (
        input  drv_req, drv_data, err_clr,
        output drv_grant, ebus_data, ebus_valid, owner_idx, hold_err, hold_err_idx
    );

endinterface

// File: rtl/ebus_arb_mux_rr_pick.sv
// Combinational round-robin selector: first requester after last_owner, wrapping.
module rr_pick #(
    parameter int N_DRV = 30,
    parameter int IDX_W = $clog2(N_DRV)
) (
    input  logic [N_DRV-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    logic [IDX_W-1:0] idx_s;
    logic             hit_s;

    // Scan last_owner+1 .. last_owner+N_DRV (mod N_DRV); first hit wins
    always_comb begin
        winner = {IDX_W{1'b0}};
        any    = 1'b0;
        idx_s  = {IDX_W{1'b0}};
        hit_s  = 1'b0;
        for (int i = 1; i <= N_DRV; i++) begin
            idx_s  = IDX_W'((int'(last_owner) + i) % N_DRV);
            hit_s  = req[idx_s] & ~any;
            winner = hit_s ? idx_s : winner;
            any    = any | hit_s;
        end
    end

endmodule

// File: rtl/ebus_arb_mux.sv
// Registered round-robin EBUS arbiter/mux with turnaround cycle.
// Optional bus-hold watchdog enabled by defining EBUS_HOLD_WATCHDOG_EN.
module ebus_arb_mux
    import ebus_pkg::*;
#(
    parameter int N_DRV    = EBUS_N_DRV,
    parameter int DATA_W   = EBUS_DATA_W,
    parameter int HOLD_MAX = 64
) (
    input logic           clk,
    input logic           crobar_e_l,
    ebus_arb_mux_if.slave bus
);

    localparam int IDX_W = $clog2(N_DRV);

    ebus_state_t       state_r, state_s;
    logic [IDX_W-1:0]  owner_r, owner_s, last_r, last_s, win_s;
    logic [N_DRV-1:0]  grant_r, grant_s, elig_s, mask_r;
    logic [DATA_W-1:0] data_r, data_s;
    logic              valid_r, valid_s, any_s, own_req_s, revoke_s;

    assign elig_s    = bus.drv_req & ~mask_r;
    assign own_req_s = bus.drv_req[owner_r];

    rr_pick #(.N_DRV(N_DRV), .IDX_W(IDX_W)) u_rr_pick (
        .req        (elig_s),
        .last_owner (last_r),
        .winner     (win_s),
        .any        (any_s)
    );

    // Next-state and next-output decode
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        grant_s = grant_r;
        data_s  = {DATA_W{1'b0}};
        valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_s = OWNED;
                    owner_s = win_s;
                    last_s  = win_s;
                    grant_s = {{(N_DRV-1){1'b0}}, 1'b1} << win_s;
                end else begin
                    owner_s = {IDX_W{1'b0}};
                    grant_s = {N_DRV{1'b0}};
                end
            end
            OWNED: begin
                if (!own_req_s || revoke_s) begin
                    state_s = TURN;
                    owner_s = {IDX_W{1'b0}};
                    grant_s = {N_DRV{1'b0}};
                end else begin
                    data_s  = bus.drv_data[owner_r];
                    valid_s = 1'b1;
                end
            end
            TURN: begin
                state_s = IDLE;
                owner_s = {IDX_W{1'b0}};
                grant_s = {N_DRV{1'b0}};
            end
            default: begin
                state_s = IDLE;
                owner_s = {IDX_W{1'b0}};
                grant_s = {N_DRV{1'b0}};
            end
        endcase
    end

    // State and registered bus outputs
    always_ff @(posedge clk or negedge crobar_e_l) begin
        if (!crobar_e_l) begin
            state_r <= IDLE;
            owner_r <= {IDX_W{1'b0}};
            last_r  <= IDX_W'(N_DRV - 1);
            grant_r <= {N_DRV{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            grant_r <= grant_s;
            data_r  <= data_s;
            valid_r <= valid_s;
        end
    end

    assign bus.drv_grant  = grant_r;
    assign bus.ebus_data  = data_r;
    assign bus.ebus_valid = valid_r;
    assign bus.owner_idx  = owner_r;

`ifdef EBUS_HOLD_WATCHDOG_EN
    localparam int CNT_W = $clog2(HOLD_MAX);

    logic [CNT_W-1:0] cnt_r;
    logic             hold_err_r;
    logic [IDX_W-1:0] hold_err_idx_r;

    // HOLD_MAX owned cycles have elapsed once the count reaches HOLD_MAX-1
    assign revoke_s = (state_r == OWNED) && own_req_s && (cnt_r == CNT_W'(HOLD_MAX - 1));

    // Hold counter, revoke mask and sticky error capture
    always_ff @(posedge clk or negedge crobar_e_l) begin
        if (!crobar_e_l) begin
            cnt_r          <= {CNT_W{1'b0}};
            mask_r         <= {N_DRV{1'b0}};
            hold_err_r     <= 1'b0;
            hold_err_idx_r <= {IDX_W{1'b0}};
        end else begin
            if ((state_r == OWNED) && (state_s == OWNED)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            mask_r <= (mask_r & bus.drv_req) |
                      (revoke_s ? ({{(N_DRV-1){1'b0}}, 1'b1} << owner_r) : {N_DRV{1'b0}});
            if (revoke_s) begin
                hold_err_r     <= 1'b1;
                hold_err_idx_r <= owner_r;
            end else if (bus.err_clr) begin
                hold_err_r     <= 1'b0;
                hold_err_idx_r <= {IDX_W{1'b0}};
            end else begin
                hold_err_r     <= hold_err_r;
                hold_err_idx_r <= hold_err_idx_r;
            end
        end
    end

    assign bus.hold_err     = hold_err_r;
    assign bus.hold_err_idx = hold_err_idx_r;
`else
    logic unused_s;

    assign revoke_s         = 1'b0;
    assign mask_r           = {N_DRV{1'b0}};
    assign bus.hold_err     = 1'b0;
    assign bus.hold_err_idx = {IDX_W{1'b0}};
    assign unused_s         = ^{bus.err_clr, 32'(HOLD_MAX)};
`endif

endmodule

// File: tb/tb_ebus_arb_mux.sv
// Directed self-checking bench for ebus_arb_mux (N_DRV=30, DATA_W=36, HOLD_MAX=4).
module tb_ebus_arb_mux;

    localparam int N  = 30;
    localparam int W  = 36;
    localparam int HM = 4;

    logic clk;
    logic crobar_e_l;
    int   checks   = 0;
    int   failures = 0;

    ebus_arb_mux_if #(.N_DRV(N), .DATA_W(W)) bus ();

    ebus_arb_mux #(.N_DRV(N), .DATA_W(W), .HOLD_MAX(HM)) dut (
        .clk        (clk),
        .crobar_e_l (crobar_e_l),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.drv_req  = '0;
        bus.drv_data = '0;
        bus.err_clr  = 1'b0;
        crobar_e_l   = 1'b0;
        step();
        step();
        crobar_e_l   = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_grant", 64'(bus.drv_grant), 64'h0);
        chk("rst_data", 64'(bus.ebus_data), 64'h0);
        chk("rst_valid", 64'(bus.ebus_valid), 64'h0);
        chk("rst_owner", 64'(bus.owner_idx), 64'h0);
        chk("rst_herr", 64'(bus.hold_err), 64'h0);

        // Reset mid-OWNED with driver 5 on the bus
        bus.drv_data[5] = 36'o123;
        bus.drv_req[5]  = 1'b1;
        step();
        chk("a_grant5", 64'(bus.drv_grant), 64'h20);
        chk("a_owner5", 64'(bus.owner_idx), 64'd5);
        chk("a_valid_lat", 64'(bus.ebus_valid), 64'h0);
        step();
        chk("a_valid", 64'(bus.ebus_valid), 64'h1);
        chk("a_data", 64'(bus.ebus_data), 64'o123);
        #3;
        crobar_e_l = 1'b0;
        #1;
        chk("a_async_grant", 64'(bus.drv_grant), 64'h0);
        chk("a_async_data", 64'(bus.ebus_data), 64'h0);
        chk("a_async_valid", 64'(bus.ebus_valid), 64'h0);
        chk("a_async_owner", 64'(bus.owner_idx), 64'h0);
        bus.drv_req[2] = 1'b1;
        crobar_e_l     = 1'b1;
        step();
        chk("a_post_owner", 64'(bus.owner_idx), 64'd2);
        chk("a_post_grant", 64'(bus.drv_grant), 64'h4);

        // Drivers 0,1,2 round-robin with turnaround gaps
        do_reset();
        bus.drv_data[0] = 36'o100;
        bus.drv_data[1] = 36'o101;
        bus.drv_data[2] = 36'o102;
        bus.drv_req     = 30'h7;
        step();
        chk("b_g0", 64'(bus.drv_grant), 64'h1);
        step();
        chk("b_d0a", 64'(bus.ebus_data), 64'o100);
        bus.drv_data[0] = 36'o110;
        step();
        chk("b_d0b", 64'(bus.ebus_data), 64'o110);
        bus.drv_req[0] = 1'b0;
        step();
        chk("b_turn0_valid", 64'(bus.ebus_valid), 64'h0);
        chk("b_turn0_data", 64'(bus.ebus_data), 64'h0);
        chk("b_turn0_grant", 64'(bus.drv_grant), 64'h0);
        bus.drv_req[0] = 1'b1;
        step();
        chk("b_idle0_grant", 64'(bus.drv_grant), 64'h0);
        step();
        chk("b_g1", 64'(bus.drv_grant), 64'h2);
        step();
        chk("b_d1", 64'(bus.ebus_data), 64'o101);
        bus.drv_req[1] = 1'b0;
        step();
        chk("b_turn1_valid", 64'(bus.ebus_valid), 64'h0);
        bus.drv_req[1] = 1'b1;
        step();
        step();
        chk("b_g2", 64'(bus.drv_grant), 64'h4);
        step();
        chk("b_d2", 64'(bus.ebus_data), 64'o102);
        bus.drv_req[2] = 1'b0;
        step();
        step();
        step();
        chk("b_g0_again", 64'(bus.owner_idx), 64'd0);
        chk("b_g0_again_grant", 64'(bus.drv_grant), 64'h1);

        // Single driver 7, all-ones data for three transfer cycles
        do_reset();
        bus.drv_data[7] = 36'o777777777777;
        bus.drv_req[7]  = 1'b1;
        step();
        chk("c_g7", 64'(bus.drv_grant), 64'h80);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("c_valid", 64'(bus.ebus_valid), 64'h1);
            chk("c_data", 64'(bus.ebus_data), 64'hF_FFFF_FFFF);
        end
        bus.drv_req[7] = 1'b0;
        step();
        chk("c_turn_valid", 64'(bus.ebus_valid), 64'h0);
        chk("c_turn_data", 64'(bus.ebus_data), 64'h0);
        chk("c_turn_owner", 64'(bus.owner_idx), 64'h0);

        // Wrap-around between drivers 0 and N-1
        do_reset();
        bus.drv_req[0]   = 1'b1;
        bus.drv_req[N-1] = 1'b1;
        step();
        chk("d_first0", 64'(bus.owner_idx), 64'd0);
        bus.drv_req[0] = 1'b0;
        step();
        step();
        step();
        chk("d_then29", 64'(bus.owner_idx), 64'd29);
        chk("d_then29_grant", 64'(bus.drv_grant), 64'h2000_0000);

        // Driver 3 holds its request for ten cycles
        do_reset();
        bus.drv_data[3] = 36'o333;
        bus.drv_req[3]  = 1'b1;
        step();
        chk("e_g3", 64'(bus.drv_grant), 64'h8);
`ifdef EBUS_HOLD_WATCHDOG_EN
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("e_wd_valid", 64'(bus.ebus_valid), 64'h1);
            chk("e_wd_data", 64'(bus.ebus_data), 64'o333);
        end
        step();
        chk("e_wd_revoke_grant", 64'(bus.drv_grant), 64'h0);
        chk("e_wd_revoke_valid", 64'(bus.ebus_valid), 64'h0);
        chk("e_wd_herr", 64'(bus.hold_err), 64'h1);
        chk("e_wd_hidx", 64'(bus.hold_err_idx), 64'd3);
        for (int k = 6; k <= 10; k++) begin
            step();
            chk("e_wd_masked", 64'(bus.drv_grant), 64'h0);
        end
        bus.drv_req[3] = 1'b0;
        bus.err_clr    = 1'b1;
        step();
        chk("e_wd_clr_err", 64'(bus.hold_err), 64'h0);
        chk("e_wd_clr_idx", 64'(bus.hold_err_idx), 64'h0);
        bus.err_clr    = 1'b0;
        bus.drv_req[3] = 1'b1;
        step();
        chk("e_wd_regrant", 64'(bus.drv_grant), 64'h8);
`else
        for (int k = 2; k <= 10; k++) begin
            step();
            chk("e_hold_grant", 64'(bus.drv_grant), 64'h8);
            chk("e_hold_valid", 64'(bus.ebus_valid), 64'h1);
            chk("e_hold_herr", 64'(bus.hold_err), 64'h0);
        end
        bus.drv_req[3] = 1'b0;
        step();
        chk("e_hold_release", 64'(bus.ebus_valid), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ebus_arb_mux.md
# ebus_arb_mux

Parametrised, registered EBUS data arbiter and multiplexer for the KL10PV backplane. It replaces the flat one-hot driver priority mux with the following:
- request/grant handshake;
- round-robin fairness across N drivers;
- a turnaround cycle between owners;
- an optional bus-hold watchdog.

It sits at the top of the CPU hierarchy, between the per-board EBUS drivers and the shared EBUS.data lines.

## Interface
Parameters:
- N_DRV, 30, number of EBUS driver channels (≥2)
- DATA_W, 36, EBUS data width
- HOLD_MAX, 64, max consecutive owned cycles before watchdog revoke (≥2, used only with watchdog)

Ports (clk first, reset second):
- clk  in  1  system clock; all state on rising edge
- crobar_e_l  in  1  reset, asynchronous assert, active-low (one clock; reset async active-low)
- drv_req  in  N_DRV  per-driver bus request, level, held for whole transfer
- drv_data  in  N_DRV×DATA_W  per-driver data, valid while granted
- drv_grant  out  N_DRV  one-hot (or zero) grant, registered
- ebus_data  out  DATA_W  registered bus data; '0 when no owner
- ebus_valid  out  1  high when ebus_data carries owner data
- owner_idx  out  $clog2(N_DRV)  index of current owner, 0 when idle
- hold_err  out  1  sticky watchdog error
- hold_err_idx  out  $clog2(N_DRV)  driver revoked by watchdog
- err_clr  in  1  synchronous clear of hold_err/hold_err_idx

## Operation
- FSM states: IDLE, OWNED, TURN.
- IDLE: if any eligible drv_req, pick winner round-robin, go OWNED; else stay.
- Round-robin order: search starts at last_owner+1 mod N_DRV and wraps. last_owner updates on each grant. Reset value N_DRV-1, so driver 0 wins first.
- OWNED:
  - ebus_data <= drv_data[owner] every cycle; ebus_valid=1.
  - When drv_req[owner] is sampled low, go TURN.
- TURN: one cycle; grant, valid and data all zero. Always go IDLE next.
- Requests from other drivers during OWNED/TURN are held pending, not lost; the driver must keep req high.
- Eligibility: a driver revoked by the watchdog is masked until its drv_req is sampled low once.
- Owner dropping and reasserting req in consecutive cycles: the drop is still honoured (OWNED→TURN). It re-competes in IDLE under normal round-robin order, so others get priority.
- Reset (async, any state): state=IDLE; every output, hold counter and mask clears to 0; last_owner=N_DRV-1.

## Timing
- Grant latency: req high at edge k (IDLE) → drv_grant/owner_idx valid after edge k.
- Data pipeline: ebus_valid first rises after edge k+1 with drv_data sampled at k+1. One-cycle data latency thereafter.
- Release: req low sampled at edge m → drv_grant=0, ebus_valid=0, ebus_data='0 after edge m (TURN). Next grant no earlier than after edge m+2.
- Minimum back-to-back owner gap: 2 cycles (TURN, IDLE).
- err_clr and a new watchdog event on the same edge: the new event wins (err set, idx updated).

## Configuration
- EBUS_HOLD_WATCHDOG_EN defined:
  - Hold counter runs in OWNED, cleared on entering OWNED.
  - When count reaches HOLD_MAX with req still high: forced to TURN, hold_err=1, hold_err_idx=owner, owner masked.
- Not defined:
  - No counter and no revoke; owner holds indefinitely.
  - hold_err and hold_err_idx tied 0; HOLD_MAX ignored.

## Structure
- ebus_pkg: ebus_state_t enum {IDLE, OWNED, TURN}; EBUS_DATA_W=36 default; EBUS_N_DRV=30 default.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: eligible-request vector, last_owner.
  - Outputs: winner index, any-valid.
  - Parametrised by N_DRV.

## Test plan
- Reset mid-OWNED (driver 5 granted, ebus_data=0o123) → all outputs 0 immediately; first grant afterwards goes to lowest eligible index.
- Drivers 0, 1 and 2 request together and hold → grants in order 0,1,2,0; each owner sees 2-cycle gap; ebus_data tracks owner data with 1-cycle lag.
- Single driver 7 with DATA_W=36 data 0o777777777777 for 3 cycles → ebus_valid high exactly 3 cycles, then TURN with ebus_data=0.
- Wrap-around: last_owner=N_DRV-1, requests from 0 and N_DRV-1 → 0 granted first.
- Watchdog (EBUS_HOLD_WATCHDOG_EN, HOLD_MAX=4): driver 3 holds req 10 cycles → revoked after 4 owned cycles; hold_err=1, hold_err_idx=3. Driver 3 is not regranted until req drops; err_clr clears both.
- Without EBUS_HOLD_WATCHDOG_EN, same stimulus → driver 3 owns all 10 cycles; hold_err stays 0.
